// File: rtl/nx_fifo_lvl_pkg.sv
// nx_fifo_pkg: shared definitions for the nx_fifo_lvl FIFO.
//   nx_cw()            - width of the level counters/thresholds for a given depth
//   ERR_UFL/OFL/PAR    - bit positions inside err_sticky
//   nx_fifo_lvl_err_t  - err_sticky type (3 bits when NX_FIFO_LVL_PARITY_EN is defined)
package nx_fifo_pkg;

  // The counter must be able to hold DEPTH itself, hence depth+1.
  function automatic int nx_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int ERR_UFL = 0;
  localparam int ERR_OFL = 1;
  localparam int ERR_PAR = 2;

`ifdef NX_FIFO_LVL_PARITY_EN
  localparam int ERR_W = 3;
`else
  localparam int ERR_W = 2;
`endif

  typedef logic [ERR_W-1:0] nx_fifo_lvl_err_t;

endpackage

// File: rtl/nx_fifo_lvl_if.sv
// nx_fifo_lvl_if: request/response bundle for nx_fifo_lvl.
//   master modport: drives wen, ren, clear, clr_err, wdata, afull_lvl, aempty_lvl
//                   and observes data, flags, levels and error status.
//   slave modport : the FIFO side (mirror of master).
//   par_err is present only when NX_FIFO_LVL_PARITY_EN is defined.
interface nx_fifo_lvl_if
  import nx_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CW    = nx_cw(16)
);
  logic             wen;
  logic             ren;
  logic             clear;
  logic             clr_err;
  logic [WIDTH-1:0] wdata;
  logic [CW-1:0]    afull_lvl;
  logic [CW-1:0]    aempty_lvl;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    used_slots;
  logic [CW-1:0]    free_slots;
  logic             overflow;
  logic             underflow;
  nx_fifo_lvl_err_t err_sticky;
`ifdef NX_FIFO_LVL_PARITY_EN
  logic             par_err;
`endif

  modport master (
    output wen, ren, clear, clr_err, wdata, afull_lvl, aempty_lvl,
`ifdef NX_FIFO_LVL_PARITY_EN
    input  par_err,
`endif
    input  rdata, empty, full, almost_full, almost_empty,
           used_slots, free_slots, overflow, underflow, err_sticky
  );

  modport slave (
    input  wen, ren, clear, clr_err, wdata, afull_lvl, aempty_lvl,
`ifdef NX_FIFO_LVL_PARITY_EN
    output par_err,
`endif
    output rdata, empty, full, almost_full, almost_empty,
           used_slots, free_slots, overflow, underflow, err_sticky
  );

endinterface

// File: rtl/nx_fifo_lvl_ctrl.sv
// nx_fifo_lvl_ctrl: pointer/occupancy/error control for nx_fifo_lvl.
// Inputs : clk, rst_n, wen_i, ren_i, clear_i, clr_err_i, afull_lvl_i, aempty_lvl_i,
//          par_err_i (only with NX_FIFO_LVL_PARITY_EN)
// Outputs: wr_ok_o/rd_ok_o (accepted transfers), wptr_o/rptr_o (storage indices),
//          empty/full/almost flags, used/free counts, overflow/underflow pulses,
//          err_sticky_o.
module nx_fifo_lvl_ctrl
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = nx_cw(16),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen_i,
  input  logic             ren_i,
  input  logic             clear_i,
  input  logic             clr_err_i,
  input  logic [CW-1:0]    afull_lvl_i,
  input  logic [CW-1:0]    aempty_lvl_i,
`ifdef NX_FIFO_LVL_PARITY_EN
  input  logic             par_err_i,
`endif
  output logic             wr_ok_o,
  output logic             rd_ok_o,
  output logic [PW-1:0]    wptr_o,
  output logic [PW-1:0]    rptr_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    used_slots_o,
  output logic [CW-1:0]    free_slots_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output nx_fifo_lvl_err_t err_sticky_o
);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ufl_q, ufl_d;
  nx_fifo_lvl_err_t err_q, err_d;
  logic             empty, full, rd_ok, wr_ok;

  // Explicit wrap so non-power-of-two depths leave no unused slots.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  // clear wins over both requests; a full FIFO still takes a write if a read frees a slot.
  assign rd_ok = ren_i & ~empty & ~clear_i;
  assign wr_ok = wen_i & (~full | rd_ok) & ~clear_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok) wptr_d = ptr_inc(wptr_q);
      if (rd_ok) rptr_d = ptr_inc(rptr_q);
      if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
      else if (rd_ok && !wr_ok) cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = wen_i & ~wr_ok & ~clear_i;
    ufl_d = ren_i & empty & ~clear_i;
    // Clear first, then OR in new events so a coincident event survives clr_err.
    err_d = clr_err_i ? '0 : err_q;
    if (ovf_d) err_d[ERR_OFL] = 1'b1;
    if (ufl_d) err_d[ERR_UFL] = 1'b1;
`ifdef NX_FIFO_LVL_PARITY_EN
    if (rd_ok && par_err_i) err_d[ERR_PAR] = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      ufl_q  <= 1'b0;
      err_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      ufl_q  <= ufl_d;
      err_q  <= err_d;
    end
  end

  assign wr_ok_o        = wr_ok;
  assign rd_ok_o        = rd_ok;
  assign wptr_o         = wptr_q;
  assign rptr_o         = rptr_q;
  assign empty_o        = empty;
  assign full_o         = full;
  // Thresholds above DEPTH simply never/always match since cnt_q <= DEPTH.
  assign almost_full_o  = (cnt_q >= afull_lvl_i);
  assign almost_empty_o = (cnt_q <= aempty_lvl_i);
  assign used_slots_o   = cnt_q;
  assign free_slots_o   = CW'(DEPTH) - cnt_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = ufl_q;
  assign err_sticky_o   = err_q;

endmodule

// File: rtl/nx_fifo_lvl.sv
// nx_fifo_lvl: single-clock show-ahead FIFO with arbitrary DEPTH, programmable
// almost-full/almost-empty levels, write-through when full and sticky errors.
// Ports: clk, rst_n (async, active-low), bus (nx_fifo_lvl_if.slave).
// Optional macro NX_FIFO_LVL_PARITY_EN adds a stored even-parity bit per entry,
// the par_err output and err_sticky[ERR_PAR].
// This level holds only the storage array, the read mux and parity.
module nx_fifo_lvl
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 64,
  parameter int DATA_RESET = 1
) (
  input logic         clk,
  input logic         rst_n,
  nx_fifo_lvl_if.slave bus
);

  localparam int CW = nx_cw(DEPTH);
  localparam int PW = $clog2(DEPTH);
`ifdef NX_FIFO_LVL_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] wentry, head;
  logic [PW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok, empty;

`ifdef NX_FIFO_LVL_PARITY_EN
  logic          par_err;
  assign wentry  = {^bus.wdata, bus.wdata};
`else
  assign wentry  = bus.wdata;
`endif

  nx_fifo_lvl_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .wen_i          (bus.wen),
    .ren_i          (bus.ren),
    .clear_i        (bus.clear),
    .clr_err_i      (bus.clr_err),
    .afull_lvl_i    (bus.afull_lvl),
    .aempty_lvl_i   (bus.aempty_lvl),
`ifdef NX_FIFO_LVL_PARITY_EN
    .par_err_i      (par_err),
`endif
    .wr_ok_o        (wr_ok),
    .rd_ok_o        (rd_ok),
    .wptr_o         (wptr),
    .rptr_o         (rptr),
    .empty_o        (empty),
    .full_o         (bus.full),
    .almost_full_o  (bus.almost_full),
    .almost_empty_o (bus.almost_empty),
    .used_slots_o   (bus.used_slots),
    .free_slots_o   (bus.free_slots),
    .overflow_o     (bus.overflow),
    .underflow_o    (bus.underflow),
    .err_sticky_o   (bus.err_sticky)
  );

  generate
    if (DATA_RESET != 0) begin : g_mem_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
          mem_q[wptr] <= wentry;
        end
      end
    end else begin : g_mem_nrst
      always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr] <= wentry;
      end
    end
  endgenerate

  assign head      = mem_q[rptr];
  assign bus.empty = empty;
  assign bus.rdata = ((DATA_RESET != 0) && empty) ? '0 : head[WIDTH-1:0];

`ifdef NX_FIFO_LVL_PARITY_EN
  assign par_err     = ~empty & ((^head[WIDTH-1:0]) != head[WIDTH]);
  assign bus.par_err = par_err;
`endif

endmodule

// File: doc/nx_fifo_lvl.md
Name: nx_fifo_lvl

Overview:
Parametrised successor of the single-clock nx_fifo. It supports arbitrary (non-power-of-two) DEPTH and any WIDTH, and adds runtime-programmable almost-full/almost-empty levels and write-through when full. Overflow/underflow are registered pulses, with sticky error status. It is a drop-in buffer for datapath and control queues inside one clock domain.

Parameters:
DEPTH, 16, number of entries; any integer >= 2
WIDTH, 64, data width in bits; >= 1
DATA_RESET, 1, 1: rdata forced to 0 when empty and storage cleared on reset; 0: storage not reset, rdata unmasked
CW, $clog2(DEPTH+1), width of level counters and thresholds (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, reset is asynchronous and active-low
wen  input  1  write request
ren  input  1  read request (show-ahead: rdata valid the same cycle)
clear  input  1  synchronous flush of contents and pointers
clr_err  input  1  clears sticky error bits
wdata  input  WIDTH  write data
afull_lvl  input  CW  almost_full asserted when used_slots >= afull_lvl
aempty_lvl  input  CW  almost_empty asserted when used_slots <= aempty_lvl
rdata  output  WIDTH  head entry
empty  output  1  used_slots == 0
full  output  1  used_slots == DEPTH
almost_full  output  1  level compare, combinational from counter
almost_empty  output  1  level compare, combinational from counter
used_slots  output  CW  occupancy
free_slots  output  CW  DEPTH - used_slots
overflow  output  1  registered 1-cycle pulse
underflow  output  1  registered 1-cycle pulse
err_sticky  output  2  {overflow_seen, underflow_seen}

Behaviour:
- Reset values: used_slots=0, free_slots=DEPTH, empty=1, full=0, overflow=underflow=0, err_sticky=0, rptr=wptr=0. almost_empty=1 and almost_full=(afull_lvl==0).
- Read acceptance: rd_ok = ren & !empty.
- Write acceptance: wr_ok = wen & (!full | rd_ok). A write when full with a simultaneous accepted read is legal; occupancy stays DEPTH.
- Empty with wen&ren: the write is accepted and the read is rejected; underflow pulses. There is no bypass of data from wdata to rdata.
- Pointers wrap explicitly at DEPTH-1 -> 0. Modulo-2^n wrap is not used.
- used_slots next value: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- rdata = mem[rptr] combinationally. When DATA_RESET=1, rdata=0 while empty.
- Error pulses:
  - overflow is asserted the cycle after wen & !wr_ok.
  - underflow is asserted the cycle after ren & empty.
  - Each pulse sets the corresponding err_sticky bit.
- clr_err clears err_sticky the next cycle. If a new event coincides with clr_err, set wins.
- clear:
  - Pointers and counter return to reset values the next cycle.
  - clear has priority over wen/ren that cycle; those requests are ignored and do not flag overflow/underflow.
  - clear does not touch err_sticky or storage.
- Level compares are unsigned. afull_lvl > DEPTH means almost_full is never asserted. aempty_lvl >= DEPTH means almost_empty is always asserted.
- Asynchronous reset mid-operation discards contents immediately. Storage is zeroed only when DATA_RESET=1.
- Latency: a write is visible at rdata the cycle after wr_ok; flags update the same edge.

Optional Feature:
NX_FIFO_LVL_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from wdata.
  - Output port par_err (1 bit) is combinational: asserted when !empty and the parity recomputed over rdata mismatches the stored bit.
  - err_sticky widens to 3 bits, with the MSB = parity_seen, set on rd_ok & par_err.
- Undefined: no parity storage, no par_err port, err_sticky is 2 bits.

Decomposition:
- Package nx_fifo_pkg holds:
  - the function for the CW width calculation;
  - the err_sticky bit-index localparams (ERR_UFL=0, ERR_OFL=1, ERR_PAR=2);
  - the typedef nx_fifo_lvl_err_t.
- Sub-module nx_fifo_lvl_ctrl contains the pointers, counter, acceptance logic, level compares and error registers. The top level holds only the storage array, the rdata mux and optional parity.

Test Plan:
- DEPTH=5, WIDTH=8: write 0x11..0x55 -> full=1, used=5, free=0. Read 5 entries -> data in order 0x11..0x55, empty=1, pointers wrapped 4->0 with no gap.
- Full FIFO, wen&ren with wdata=0xAA -> overflow=0, used stays 5. After 5 further reads, 0xAA is the last entry out.
- Empty FIFO, ren=1 -> underflow=1 for exactly one cycle, err_sticky=2'b01, rdata=0. Then clr_err -> err_sticky=0. Event coinciding with clr_err -> bit stays set.
- afull_lvl=4, aempty_lvl=1: fill 0->5 -> almost_empty=1 at used 0..1, almost_full=1 at used 4..5. Set afull_lvl=6 -> almost_full never asserted.
- used=3, clear with wen&ren asserted -> next cycle used=0, empty=1, no overflow/underflow pulse, err_sticky unchanged.
- With NX_FIFO_LVL_PARITY_EN: force a stored bit flip via backdoor, then read -> par_err=1 on that entry, err_sticky[2]=1. Asynchronous reset mid-fill (used=3) -> used=0 and all outputs at reset values immediately.
